// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-port memory between the RV32I
// instruction-fetch port and the data port. One transaction is outstanding
// at a time; data has priority, with a starvation counter that forces fetch
// to win after STARVE_LIMIT consecutive data grants. Byte enables, lane
// replicated store data and right-aligned load data are built here.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY state after
// TIMEOUT_CYCLES cycles without mem_ack.
module rv32i_mem_arbiter #(
  parameter int STARVE_LIMIT   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [1:0]  off_q, size_q;
  logic        if_valid_q, d_valid_q, timeout_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  logic        misalign, fetch_win, data_win, data_go, done, timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, shifted, load_data;
  logic        unused_if_addr;

  assign unused_if_addr = ^if_addr[1:0];

  // IDLE arbitration: fetch wins only when data is absent or fetch is starving
  always_comb begin
    misalign = 1'b0;
    case (d_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = d_addr[0];
      default: misalign = |d_addr[1:0];
    endcase
    fetch_win = (state_q == IDLE) && !reset && if_req && (!d_req || (starve_q == StarveMax));
    data_win  = (state_q == IDLE) && !reset && d_req && !fetch_win;
    data_go   = data_win && !misalign;
  end

  assign done = (state_q != IDLE) && (mem_ack || timeout_hit);

  // Next state and starvation count; misaligned rejects leave both untouched
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (fetch_win)    state_d = BUSY_IF;
        else if (data_go) state_d = BUSY_D;
      end
      default: begin
        if (done) state_d = IDLE;
      end
    endcase
    if (!if_req || fetch_win)                    starve_d = 4'd0;
    else if (data_go && (starve_q != StarveMax)) starve_d = starve_q + 4'd1;
  end

  // Lane formatting for stores and right alignment for loads
  always_comb begin
    be_calc    = 4'hF;
    wdata_calc = d_wdata;
    case (d_size)
      2'b00: begin
        be_calc    = 4'b0001 << d_addr[1:0];
        wdata_calc = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << d_addr[1:0];
        wdata_calc = {2{d_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'hF;
        wdata_calc = d_wdata;
      end
    endcase
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = {24'd0, shifted[7:0]};
      2'b01:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt_q;

  assign timeout_hit = (state_q != IDLE) && !mem_ack && (tcnt_q == TimeoutLast);

  // Counts cycles spent waiting in a BUSY state; restarts with every transaction
  always_ff @(posedge clk) begin
    if (reset || (state_q == IDLE) || done) tcnt_q <= 16'd0;
    else                                    tcnt_q <= tcnt_q + 16'd1;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  // State, memory request registers and registered completion pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      timeout_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      timeout_q  <= 1'b0;
      if (fetch_win) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= {if_addr[31:2], 2'b00};
        mem_be_q    <= 4'hF;
        mem_wdata_q <= 32'd0;
      end else if (data_go) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= d_we;
        mem_addr_q  <= {d_addr[31:2], 2'b00};
        mem_be_q    <= be_calc;
        mem_wdata_q <= wdata_calc;
        off_q       <= d_addr[1:0];
        size_q      <= d_size;
      end else if (done) begin
        mem_req_q <= 1'b0;
        timeout_q <= timeout_hit;
        if (state_q == BUSY_IF) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= timeout_hit ? 32'd0 : mem_rdata;
        end else begin
          d_valid_q <= 1'b1;
          d_rdata_q <= (timeout_hit || mem_we_q) ? 32'd0 : load_data;
        end
      end
    end
  end

  assign if_gnt      = fetch_win;
  assign d_gnt       = data_win;
  assign d_misalign  = data_win && misalign;
  assign if_valid    = if_valid_q;
  assign if_rdata    = if_rdata_q;
  assign d_valid     = d_valid_q;
  assign d_rdata     = d_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_timeout = timeout_q;

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
Shares one single-port memory between the RV32I instruction-fetch port (pc) and the data port (MemAddr/MemRead/MemWrite/addMemControl).
- Three-state FSM, one transaction outstanding.
- Data side has priority; an anti-starvation counter protects fetch.
- Generates byte enables, lane-replicated write data and right-aligned read data from the access size.
- Sits between the CPU core and the memory model.

Parameters:
STARVE_LIMIT, 3, consecutive data grants allowed while if_req is pending before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 16, cycles in BUSY without mem_ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  32  fetch address (pc), word-aligned
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_valid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  32  fetched instruction
d_req  in  1  data request (MemRead|MemWrite), held until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  32  data address (MemAddr)
d_size  in  2  addMemControl: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
d_wdata  in  32  store data, right-aligned
d_gnt  out  1  data request accepted (1-cycle pulse)
d_valid  out  1  data transaction complete (1-cycle pulse, loads and stores)
d_rdata  out  32  load data, right-aligned, zero-extended
d_misalign  out  1  misaligned request rejected (1-cycle pulse, with d_gnt)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  32  {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read word
mem_ack  in  1  memory completes current request this cycle
mem_timeout  out  1  timeout abort pulse (0 when feature off)

Behaviour:
- Reset: FSM=IDLE; starve count=0; all outputs 0 (gnt/valid/misalign/timeout pulses, mem_req/we/addr/be/wdata, if_rdata, d_rdata).
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE arbitration, evaluated each cycle:
  - Fetch wins if if_req && (!d_req || starve==STARVE_LIMIT); otherwise data wins if d_req.
  - Winner: gnt pulses this cycle; request latched into mem_* registers (visible next cycle); FSM -> BUSY_IF or BUSY_D.
- Starve counter:
  - Data grant with if_req high: +1, saturating at STARVE_LIMIT.
  - Any fetch grant, or if_req low: cleared.
- Misalignment: d_size=01 with d_addr[0]=1, or word with d_addr[1:0]!=0.
  - If data would win: d_gnt and d_misalign pulse together; no memory access; FSM stays IDLE; starve counter unchanged.
  - Fetch may be granted the following cycle.
- Byte enables (off = d_addr[1:0]): byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111. Fetch always 4'b1111, mem_we=0.
- mem_wdata: byte {4{d_wdata[7:0]}}; half {2{d_wdata[15:0]}}; word d_wdata.
- BUSY_x: mem_req=1, all mem_* stable until mem_ack.
  - On mem_ack: mem_req drops next cycle; the matching valid pulses next cycle with rdata registered; FSM -> IDLE.
  - Load data: d_rdata = (mem_rdata >> 8*off), masked to 8/16/32 bits. Store: d_valid pulses, d_rdata=0.
- Latency: grant in cycle N; mem_req high N+1; ack at N+k (k>=1); valid at N+k+1. New grant earliest at N+k+1 (IDLE re-entered).
- Simultaneous if_req/d_req in IDLE: data wins unless starve==STARVE_LIMIT.
- Requests arriving during BUSY wait; no gnt while BUSY.
- Reset mid-transaction: next cycle FSM=IDLE and mem_req=0; a late mem_ack in IDLE is ignored; no valid produced.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a cycle counter runs in BUSY states. After TIMEOUT_CYCLES cycles without mem_ack: drop mem_req; pulse mem_timeout together with the owner's valid; rdata=32'h0; FSM -> IDLE.
- Undefined: no counter; BUSY waits indefinitely; mem_timeout tied 0.

Test Plan:
- Reset mid-BUSY_D (mem_req=1, no ack) -> next cycle mem_req=0, IDLE; ack asserted a cycle later -> no d_valid, no if_valid.
- Fetch only: if_req, if_addr=0x100, ack 2 cycles after mem_req with mem_rdata=0x00A00093 -> mem_be=4'hF, if_valid 1 cycle after ack, if_rdata=0x00A00093.
- Byte store: d_we=1, d_addr=0x203, d_size=00, d_wdata=0xAB -> mem_addr=0x200, mem_be=4'b1000, mem_wdata=0xABABABAB; half load at 0x202 with mem_rdata=0x12345678 -> d_rdata=0x00001234.
- Misaligned word load at 0x102 -> d_gnt and d_misalign same cycle, mem_req stays 0, FSM IDLE.
- if_req and d_req held constantly, STARVE_LIMIT=3 -> grant order D,D,D,F,D,D,D,F.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> mem_timeout and if_valid pulse, if_rdata=0, mem_req low afterwards.
